dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache for the MEM stage of the 5-stage pipeline. It sits between the pipeline's memory-access port (MemRead/MemWrite, ALU-result address, forwarded store data) and a slow 256-bit-line off-chip data memory. On a miss it raises a stall that freezes the whole pipeline until the line is resident.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_sram.sv | 65 ++++++
 rtl/dcache_controller.sv | 183 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address field widths, the controller state encoding and the line record.
package dcache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned LINE_NUM  = 32;
    localparam int unsigned TAG_W     = 22;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned OFF_W     = 5;
    localparam int unsigned WSEL_W    = 3;
    localparam int unsigned CNT_W     = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_W-1:0]     tag;
        logic [LINE_BITS-1:0] data;
    } line_t;

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: valid/dirty/tag/data per line.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low clear of valid/dirty
//   rd_idx / rd_line_c            asynchronous read of one line by index
//   line_we/line_idx/line_in      whole-line write (fill)
//   word_we/word_idx/word_sel/    single-word store, also marks the line dirty
//   word_data
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx,
    output line_t             rd_line_c,
    input  logic              line_we,
    input  logic [IDX_W-1:0]  line_idx,
    input  line_t             line_in,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0] word_data
);

    logic                 valid_q [LINE_NUM];
    logic                 dirty_q [LINE_NUM];
    logic [TAG_W-1:0]     tag_q   [LINE_NUM];
    logic [LINE_BITS-1:0] data_q  [LINE_NUM];

    // Status bits: the only state that reset has to clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(LINE_NUM); i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            if (line_we) begin
                valid_q[line_idx] <= line_in.valid;
                dirty_q[line_idx] <= line_in.dirty;
            end
            if (word_we) begin
                dirty_q[word_idx] <= 1'b1;
            end
        end
    end

    // Tag and data payload; contents are meaningless until valid is set.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[line_idx]  <= line_in.tag;
            data_q[line_idx] <= line_in.data;
        end
        if (word_we) begin
            data_q[word_idx][{word_sel, 5'd0} +: WORD_W] <= word_data;
        end
    end

    always_comb begin
        rd_line_c.valid = valid_q[rd_idx];
        rd_line_c.dirty = dirty_q[rd_idx];
        rd_line_c.tag   = tag_q[rd_idx];
        rd_line_c.data  = data_q[rd_idx];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// A miss stalls the pipeline while the victim is written back (if dirty)
// and the new 256-bit line is fetched from slow memory.
// Ports:
//   clk_i, rst_i             clock, synchronous active-low reset
//   p1_req_i/p1_write_i      pipeline access request, store when write=1
//   p1_addr_i/p1_data_i      byte address and store data
//   p1_data_o/p1_stall_o     load data and stall (both combinational)
//   mem_enable_o/mem_write_o memory request (held until ack), write-back vs fetch
//   mem_addr_o/mem_data_o    line-aligned address, write-back line
//   mem_data_i/mem_ack_i     fetched line and one-cycle completion pulse
//   hit_cnt_o/miss_cnt_o     access statistics, present only with DCACHE_STATS_EN
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_req_i,
    input  logic                 p1_write_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [WORD_W-1:0]    p1_data_i,
    output logic [WORD_W-1:0]    p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]     hit_cnt_o,
    output logic [CNT_W-1:0]     miss_cnt_o
`endif
);

    state_t               state_q, state_n;
    logic [TAG_W-1:0]     req_tag, miss_tag_q;
    logic [IDX_W-1:0]     req_idx, miss_idx_q;
    logic [WSEL_W-1:0]    req_wsel;
    logic [LINE_BITS-1:0] fill_q;
    line_t                line;
    line_t                fill_line;
    logic                 hit;
    logic                 miss_start;
    logic                 en_n, wr_n;
    logic [ADDR_W-1:0]    addr_n;
    logic [LINE_BITS-1:0] data_n;
    logic                 unused_addr_bits;

    assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
    assign req_wsel         = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    assign fill_line.valid = 1'b1;
    assign fill_line.dirty = 1'b0;
    assign fill_line.tag   = miss_tag_q;
    assign fill_line.data  = fill_q;

    dcache_sram u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx    (req_idx),
        .rd_line_c (line),
        .line_we   (state_q == FILL),
        .line_idx  (miss_idx_q),
        .line_in   (fill_line),
        .word_we   (hit & p1_write_i),
        .word_idx  (req_idx),
        .word_sel  (req_wsel),
        .word_data (p1_data_i)
    );

    // Pipeline-side lookup; only IDLE can produce a hit.
    assign hit        = p1_req_i & line.valid & (line.tag == req_tag) & (state_q == IDLE);
    assign p1_stall_o = p1_req_i & ~hit;
    assign p1_data_o  = (hit & ~p1_write_i) ? line.data[{req_wsel, 5'd0} +: WORD_W] : '0;
    assign miss_start = (state_q == IDLE) & (state_n != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state_q      <= state_n;
            mem_enable_o <= en_n;
            mem_write_o  <= wr_n;
            mem_addr_o   <= addr_n;
            mem_data_o   <= data_n;
        end
    end

    // Next state, plus next values of the registered memory-side outputs.
    // Victim tag/data are captured on entry to WRITEBACK and then held, so
    // they stay stable even if the pipeline address changes mid-miss.
    always_comb begin
        state_n = state_q;
        en_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = '0;
        data_n  = '0;

        case (state_q)
            IDLE: begin
                if (p1_req_i & ~hit) begin
                    state_n = (line.valid & line.dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: if (mem_ack_i) state_n = FETCH;
            FETCH:     if (mem_ack_i) state_n = FILL;
            FILL:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        case (state_n)
            WRITEBACK: begin
                en_n = 1'b1;
                wr_n = 1'b1;
                if (state_q == IDLE) begin
                    addr_n = {line.tag, req_idx, {OFF_W{1'b0}}};
                    data_n = line.data;
                end else begin
                    addr_n = mem_addr_o;
                    data_n = mem_data_o;
                end
            end
            FETCH: begin
                en_n = 1'b1;
                if (state_q == IDLE) begin
                    addr_n = {req_tag, req_idx, {OFF_W{1'b0}}};
                end else begin
                    addr_n = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                end
            end
            default: ;
        endcase
    end

    // Miss address is latched at miss start; the fetched line on the fetch ack.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            fill_q     <= '0;
        end else begin
            if (miss_start) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
            if ((state_q == FETCH) && mem_ack_i) begin
                fill_q <= mem_data_i;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // The first IDLE cycle after FILL resolves an already-counted miss.
    logic resolving_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            resolving_q <= 1'b0;
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
        end else begin
            resolving_q <= (state_q == FILL);
            if (hit & ~resolving_q) begin
                hit_cnt_o <= hit_cnt_o + CNT_W'(1);
            end
            if (miss_start) begin
                miss_cnt_o <= miss_cnt_o + CNT_W'(1);
            end
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: hit-path vector table plus
// hand-written miss, write-back, reset-abort and statistics sequences.
module tb_dcache_controller;

    logic         clk;
    logic         rst;
    logic         req;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_en;
    logic         mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dcache_controller dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_req_i     (req),
        .p1_write_i   (wr),
        .p1_addr_i    (addr),
        .p1_data_i    (wdata),
        .p1_data_o    (rdata),
        .p1_stall_o   (stall),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_line(input logic [255:0] l);
        mem_rdata = l;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        req  = 1'b1;
        wr   = 1'b0;
        addr = a;
        #1;
        check({name, "_stall"}, 256'(stall), 256'(1'b0));
        check({name, "_data"}, 256'(rdata), 256'(exp));
        tick();
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    logic [255:0] line_a, line_b, line_c, line_d, exp_wb;

    initial begin
        line_a = make_line(32'hA000_0000);
        line_a[31:0] = 32'h1234_5678;
        line_b = make_line(32'hB000_0000);
        line_c = make_line(32'hC000_0000);
        line_d = make_line(32'hD000_0000);

        // Hit-path vectors on the line at 0x400 (tag 1, index 0).
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,         1'b0, 32'hA000_0002};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_041C, 32'h0,         1'b0, 32'hA000_0007};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0,         1'b0, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0418, 32'h55AA_55AA, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0418, 32'h0,         1'b0, 32'h55AA_55AA};

        exp_wb = line_a;
        exp_wb[63:32]   = 32'hDEAD_BEEF;
        exp_wb[223:192] = 32'h55AA_55AA;

        rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_mem_en",   256'(mem_en),   256'(1'b0));
        check("rst_mem_wr",   256'(mem_wr),   256'(1'b0));
        check("rst_mem_addr", 256'(mem_addr), 256'(32'h0));
        check("rst_stall",    256'(stall),    256'(1'b0));

        // Cold load miss at 0x400.
        rst = 1'b1; req = 1'b1; addr = 32'h0000_0400;
        #1;
        check("cold_stall", 256'(stall), 256'(1'b1));
        tick();
        check("cold_fetch_en",   256'(mem_en),   256'(1'b1));
        check("cold_fetch_wr",   256'(mem_wr),   256'(1'b0));
        check("cold_fetch_addr", 256'(mem_addr), 256'(32'h0000_0400));
        tick();
        tick();
        check("cold_wait_en",   256'(mem_en),   256'(1'b1));
        check("cold_wait_addr", 256'(mem_addr), 256'(32'h0000_0400));
        check("cold_wait_stall", 256'(stall),   256'(1'b1));
        ack_line(line_a);
        check("cold_fill_en",    256'(mem_en), 256'(1'b0));
        check("cold_fill_stall", 256'(stall),  256'(1'b1));
        tick();
        check("cold_hit_stall", 256'(stall), 256'(1'b0));
        check("cold_hit_data",  256'(rdata), 256'(32'h1234_5678));
        tick();

        for (int i = 0; i < 8; i++) begin
            req   = vecs[i].req;
            wr    = vecs[i].wr;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_stall", i), 256'(stall), 256'(vecs[i].exp_stall));
            check($sformatf("vec%0d_data", i),  256'(rdata), 256'(vecs[i].exp_data));
            tick();
        end

        // Conflict miss on a dirty line: write-back 0x400, then fetch 0x800.
        req = 1'b1; wr = 1'b0; addr = 32'h0000_0804;
        #1;
        check("wb_stall0", 256'(stall), 256'(1'b1));
        tick();
        check("wb_en",    256'(mem_en),    256'(1'b1));
        check("wb_wr",    256'(mem_wr),    256'(1'b1));
        check("wb_addr",  256'(mem_addr),  256'(32'h0000_0400));
        check("wb_data",  mem_wdata,       exp_wb);
        check("wb_stall", 256'(stall),     256'(1'b1));
        tick();
        check("wb_hold_addr", 256'(mem_addr), 256'(32'h0000_0400));
        check("wb_hold_data", mem_wdata,      exp_wb);
        ack_line('0);
        check("wbf_en",    256'(mem_en),   256'(1'b1));
        check("wbf_wr",    256'(mem_wr),   256'(1'b0));
        check("wbf_addr",  256'(mem_addr), 256'(32'h0000_0800));
        check("wbf_stall", 256'(stall),    256'(1'b1));
        ack_line(line_b);
        check("wbf_fill_stall", 256'(stall), 256'(1'b1));
        tick();
        check("wbf_hit_stall", 256'(stall), 256'(1'b0));
        check("wbf_hit_data",  256'(rdata), 256'(32'hB000_0001));
        tick();

        // Stray ack in IDLE has no effect.
        req = 1'b0;
        ack_line({8{32'hFFFF_FFFF}});
        check("stray_ack_en",   256'(mem_en),   256'(1'b0));
        check("stray_ack_addr", 256'(mem_addr), 256'(32'h0));
        load_check("stray_ack_hit", 32'h0000_0808, 32'hB000_0002);

        // Store miss with a clean victim: fetch only, then the store merges.
        req = 1'b1; wr = 1'b1; addr = 32'h0000_1000; wdata = 32'hCAFE_F00D;
        #1;
        check("smiss_stall", 256'(stall), 256'(1'b1));
        tick();
        check("smiss_en",   256'(mem_en),   256'(1'b1));
        check("smiss_wr",   256'(mem_wr),   256'(1'b0));
        check("smiss_addr", 256'(mem_addr), 256'(32'h0000_1000));
        ack_line(line_c);
        tick();
        check("smiss_resolve_stall", 256'(stall), 256'(1'b0));
        tick();
        load_check("smiss_w0", 32'h0000_1000, 32'hCAFE_F00D);
        load_check("smiss_w1", 32'h0000_1004, 32'hC000_0001);
        load_check("smiss_w7", 32'h0000_101C, 32'hC000_0007);

        // Merged store left the line dirty: the next conflict writes it back.
        exp_wb = line_c;
        exp_wb[31:0] = 32'hCAFE_F00D;
        req = 1'b1; wr = 1'b0; addr = 32'h0000_0400;
        tick();
        check("dirty_wb_wr",   256'(mem_wr),   256'(1'b1));
        check("dirty_wb_addr", 256'(mem_addr), 256'(32'h0000_1000));
        check("dirty_wb_data", mem_wdata,      exp_wb);
        ack_line('0);
        check("dirty_f_addr", 256'(mem_addr), 256'(32'h0000_0400));
        tick();

        // Reset during FETCH with the ack withheld.
        rst = 1'b0;
        tick();
        check("abort_en",   256'(mem_en),   256'(1'b0));
        check("abort_wr",   256'(mem_wr),   256'(1'b0));
        check("abort_addr", 256'(mem_addr), 256'(32'h0));
        rst = 1'b1; addr = 32'h0000_1004;
        #1;
        check("abort_miss_stall", 256'(stall), 256'(1'b1));
        tick();
        check("abort_refetch_wr",   256'(mem_wr),   256'(1'b0));
        check("abort_refetch_addr", 256'(mem_addr), 256'(32'h0000_1000));

        // Request dropped mid-miss: the fill still completes.
        req = 1'b0;
        ack_line(line_d);
        check("drop_fill_en", 256'(mem_en), 256'(1'b0));
        tick();
        load_check("drop_hit", 32'h0000_1008, 32'hD000_0002);

`ifdef DCACHE_STATS_EN
        req = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("stats_rst_hit",  256'(hit_cnt),  256'(32'd0));
        check("stats_rst_miss", 256'(miss_cnt), 256'(32'd0));
        req = 1'b1; wr = 1'b0; addr = 32'h0000_0400;
        tick();
        ack_line(line_a);
        tick();
        tick();
        addr = 32'h0000_0404; tick();
        addr = 32'h0000_0408; tick();
        addr = 32'h0000_0020; tick();
        ack_line(line_b);
        tick();
        tick();
        addr = 32'h0000_0024; tick();
        req = 1'b0; tick();
        check("stats_hit",  256'(hit_cnt),  256'(32'd3));
        check("stats_miss", 256'(miss_cnt), 256'(32'd2));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
